// File: rtl/mem_if_pkg.sv
// Shared definitions for the L1 lower-memory request interface.
// Imported by both the L1 data cache and the memory responder.
package mem_if_pkg;

    localparam int MEM_WORD_WIDTH = 32;
    localparam int MEM_ADDR_WIDTH = 32;

    typedef struct packed {
        logic [MEM_ADDR_WIDTH-1:0] address;
        logic                      write_enable;
        logic [MEM_WORD_WIDTH-1:0] write_data;
    } mem_req_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2,
        DRAIN   = 2'd3
    } mem_resp_state_t;

    // True when the word addressed by a byte address lies beyond the store.
    function automatic logic word_out_of_range(input logic [MEM_ADDR_WIDTH-1:0] address,
                                               input int depth_words);
        return ({2'b00, address[MEM_ADDR_WIDTH-1:2]} >= 32'(depth_words));
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Synchronous single-port word RAM: full-word writes, registered read.
// Only the read register is reset; the storage itself is not.
module mem_word_array
    import mem_if_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      write_enable,
    input  logic                      read_enable,
    input  logic [IDX_W-1:0]          index,
    input  logic [MEM_WORD_WIDTH-1:0] write_data,
    output logic [MEM_WORD_WIDTH-1:0] read_data
);

    logic [MEM_WORD_WIDTH-1:0] store [DEPTH_WORDS];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (write_enable) begin
            store[index] <= write_data;
        end
    end

    // Registered read port; holds its value between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data <= {MEM_WORD_WIDTH{1'b0}};
        end else if (read_enable) begin
            read_data <= store[index];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency main-memory stand-in for the L1 data cache: one word per
// request, single-cycle mem_ready pulse, sticky out-of-range flag.
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_request,
    input  logic                      mem_write_enable,
    input  logic [MEM_ADDR_WIDTH-1:0] mem_address,
    input  logic [MEM_WORD_WIDTH-1:0] mem_write_data,
    output logic [MEM_WORD_WIDTH-1:0] mem_response_data,
    output logic                      mem_ready,
    output logic                      busy,
    output logic                      addr_error
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    mem_resp_state_t           state, state_next;
    logic [7:0]                count, count_next;
    mem_req_t                  req, req_next;
    logic                      ready, ready_next;
    logic                      error, error_next;
    logic                      resp_zero, resp_zero_next;
    logic                      ram_write, ram_read;
    logic                      req_oor;
    logic [MEM_WORD_WIDTH-1:0] ram_data;
    logic                      unused_byte_offset;

    assign req_oor            = word_out_of_range(req.address, DEPTH_WORDS);
    assign unused_byte_offset = ^req.address[1:0];

    mem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk          (clk),
        .rst          (rst),
        .write_enable (ram_write),
        .read_enable  (ram_read),
        .index        (req.address[2 +: IDX_W]),
        .write_data   (req.write_data),
        .read_data    (ram_data)
    );

    // State, latched request and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= 8'd0;
            req       <= '0;
            ready     <= 1'b0;
            error     <= 1'b0;
            resp_zero <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            req       <= req_next;
            ready     <= ready_next;
            error     <= error_next;
            resp_zero <= resp_zero_next;
        end
    end

    // Next-state logic; the access commits on the edge leaving WAIT.
    always_comb begin
        state_next     = state;
        count_next     = count;
        req_next       = req;
        ready_next     = 1'b0;
        error_next     = error;
        resp_zero_next = resp_zero;
        ram_write      = 1'b0;
        ram_read       = 1'b0;
        case (state)
            IDLE: begin
                if (mem_request) begin
                    req_next.address      = mem_address;
                    req_next.write_enable = mem_write_enable;
                    req_next.write_data   = mem_write_data;
                    count_next            = 8'(LATENCY - 1);
                    error_next            = error | word_out_of_range(mem_address, DEPTH_WORDS);
                    state_next            = WAIT;
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (count == 8'd0) begin
                    ready_next = 1'b1;
                    state_next = RESPOND;
                    if (req.write_enable) begin
                        ram_write = ~req_oor;
                    end else begin
                        // Out-of-range reads answer zero without touching the array.
                        ram_read       = ~req_oor;
                        resp_zero_next = req_oor;
                    end
                end else begin
                    count_next = count - 8'd1;
                end
            end
            RESPOND: begin
                state_next = DRAIN;
            end
            DRAIN: begin
                if (!mem_request) begin
                    state_next = IDLE;
                end else begin
                    state_next = DRAIN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mem_ready         = ready;
    assign busy              = (state != IDLE);
    assign addr_error        = error;
    assign mem_response_data = resp_zero ? {MEM_WORD_WIDTH{1'b0}} : ram_data;

endmodule

// File: tb/tb_mem_responder.sv
// Directed scoreboard bench for mem_responder (DEPTH_WORDS=4096, LATENCY=4).
module tb_mem_responder;

    localparam int LAT   = 4;
    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_request = 1'b0;
    logic        mem_write_enable = 1'b0;
    logic [31:0] mem_address = 32'h0;
    logic [31:0] mem_write_data = 32'h0;
    logic [31:0] mem_response_data;
    logic        mem_ready;
    logic        busy;
    logic        addr_error;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model [int];
    logic [31:0] exp_q [$];
    logic [31:0] last_resp = 32'h0;

    mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_request       (mem_request),
        .mem_write_enable  (mem_write_enable),
        .mem_address       (mem_address),
        .mem_write_data    (mem_write_data),
        .mem_response_data (mem_response_data),
        .mem_ready         (mem_ready),
        .busy              (busy),
        .addr_error        (addr_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One complete transaction from the initiator side, L1-style handshake.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input int hold_extra, input bit drop_early, input string tag);
        int          key;
        bit          oor;
        int          cycles;
        int          pulses;
        bit          got;
        logic [31:0] e;
        key = int'(addr[31:2]);
        oor = (addr[31:2] >= 30'(DEPTH));
        if (we) begin
            if (!oor) model[key] = wd;
            exp_q.push_back(last_resp);
        end else begin
            e = oor ? 32'h0 : model[key];
            exp_q.push_back(e);
            last_resp = e;
        end
        mem_request      = 1'b1;
        mem_write_enable = we;
        mem_address      = addr;
        mem_write_data   = wd;
        @(posedge clk); #1;
        check({tag, "_busy_capture"}, 32'(busy), 32'd1);
        cycles = 0;
        got    = 1'b0;
        while (!got && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
            if (drop_early && cycles == 1) mem_request = 1'b0;
            check({tag, "_busy_wait"}, 32'(busy), 32'd1);
            if (mem_ready === 1'b1) got = 1'b1;
        end
        check({tag, "_latency"}, 32'(cycles), 32'(LAT));
        e = exp_q.pop_front();
        check({tag, "_data"}, mem_response_data, e);
        @(posedge clk); #1;
        check({tag, "_ready_fall"}, 32'(mem_ready), 32'd0);
        check({tag, "_busy_drain"}, 32'(busy), 32'd1);
        check({tag, "_data_held"}, mem_response_data, e);
        pulses = 0;
        for (int i = 0; i < hold_extra; i++) begin
            @(posedge clk); #1;
            if (mem_ready === 1'b1) pulses++;
            check({tag, "_busy_hold"}, 32'(busy), 32'd1);
        end
        if (hold_extra > 0) check({tag, "_extra_pulses"}, 32'(pulses), 32'd0);
        mem_request = 1'b0;
        @(posedge clk); #1;
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(mem_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(addr_error), 32'd0);
        check("rst_data", mem_response_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        access(1'b1, 32'h0000_0040, 32'hCAFE_F00D, 0, 1'b0, "wr40");
        access(1'b0, 32'h0000_0040, 32'h0, 0, 1'b0, "rd40");
        access(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 0, 1'b0, "wr44");
        access(1'b1, 32'h0000_0003, 32'hA5A5_5A5A, 0, 1'b0, "wr00");
        access(1'b0, 32'h0000_0046, 32'h0, 0, 1'b0, "rd44");
        check("err_clean", 32'(addr_error), 32'd0);

        access(1'b1, 32'h0000_4000, 32'h7777_8888, 0, 1'b0, "wr_oor");
        check("err_set", 32'(addr_error), 32'd1);
        access(1'b0, 32'h0000_4000, 32'h0, 0, 1'b0, "rd_oor");
        check("err_sticky", 32'(addr_error), 32'd1);
        access(1'b0, 32'h0000_0000, 32'h0, 0, 1'b0, "rd00_alias");
        check("err_sticky2", 32'(addr_error), 32'd1);

        access(1'b0, 32'h0000_0044, 32'h0, 10, 1'b0, "hold");
        access(1'b0, 32'h0000_0040, 32'h0, 0, 1'b1, "drop_early");

        access(1'b1, 32'h0000_0080, 32'h1111_2222, 0, 1'b0, "wr80");
        // Write of a new value to 0x80 aborted by reset during WAIT.
        mem_request      = 1'b1;
        mem_write_enable = 1'b1;
        mem_address      = 32'h0000_0080;
        mem_write_data   = 32'h1234_5678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst         = 1'b1;
        mem_request = 1'b0;
        #1;
        check("async_rst_ready", 32'(mem_ready), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_data", mem_response_data, 32'h0);
        check("async_rst_err", 32'(addr_error), 32'd0);
        last_resp        = 32'h0;
        mem_request      = 1'b1;
        mem_write_enable = 1'b0;
        mem_address      = 32'h0000_0080;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        access(1'b0, 32'h0000_0080, 32'h0, 0, 1'b0, "rd80_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
